// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;
  localparam int INST_BYTES = 4;
  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_t;
  typedef struct packed {
    addr_t pc;
    word_t inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and decode handshake bundle.
interface fetch_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry prefetch FIFO; pointers carry an extra wrap bit to tell full from empty.
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  assign count_o = wr_q - rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = count_o == (AW+1)'(DEPTH);
  assign data_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q <= wr_q;
    end else begin
      if (push_i) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single-outstanding imem fetch FSM and prefetch FIFO feeding decode.
// Define FETCH_BYPASS_EN to forward a returning word straight to decode when the FIFO is empty.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, redir_pc;
  logic redir, ack_ok, push, pop, slot, f_empty, f_full;
  logic [CW-1:0] f_count, count_nx;
  logic [ADDR_W+DATA_W-1:0] head;
  assign redir    = bus.redirect_valid;
  assign redir_pc = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign ack_ok   = state_q == REQ && bus.imem_ack && !redir;
  assign pop      = !f_empty && bus.inst_ready;
`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass         = ack_ok && f_empty;
  assign push           = ack_ok && !(bypass && bus.inst_ready);
  assign bus.inst_valid = !f_empty || bypass;
  assign bus.inst_data  = bypass ? bus.imem_rdata : head[DATA_W-1:0];
  assign bus.inst_pc    = bypass ? pc_q : head[ADDR_W+DATA_W-1:DATA_W];
`else
  assign push           = ack_ok;
  assign bus.inst_valid = !f_empty;
  assign bus.inst_data  = head[DATA_W-1:0];
  assign bus.inst_pc    = head[ADDR_W+DATA_W-1:DATA_W];
`endif
  // Occupancy after this edge; a new request may only go out if it still leaves room for its word.
  assign count_nx = redir ? '0 : f_count + CW'(push) - CW'(pop);
  assign slot     = count_nx < CW'(DEPTH);
  fetch_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push && (!f_full || pop)),
    .pop_i   (pop),
    .flush_i (redir),
    .data_i  ({pc_q, bus.imem_rdata}),
    .data_o  (head),
    .count_o (f_count),
    .full_o  (f_full),
    .empty_o (f_empty)
  );
  always_comb begin
    state_d = state_q;
    pc_d = redir ? redir_pc : pc_q;
    case (state_q)
      IDLE: state_d = (!redir && slot) ? REQ : IDLE;
      REQ:
        if (bus.imem_ack) begin
          state_d = slot ? REQ : IDLE;
          pc_d = redir ? redir_pc : pc_q + ADDR_W'(INST_BYTES);
        end else if (redir) begin
          state_d = DROP;
        end
      DROP: state_d = bus.imem_ack ? REQ : DROP;
      default: state_d = IDLE;
    endcase
    addr_d = state_d == DROP ? addr_q : pc_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
    end
  end
  assign bus.imem_req  = state_q != IDLE;
  assign bus.imem_addr = addr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios against a latency-programmable instruction memory.
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  int mem_lat = 1;
  int wcnt = 0;
  fetch_entry_t got[$];
  addr_t acked[$];
  localparam logic [31:0] XK = 32'hA5A5_0000;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask
  task automatic mem_model();
    if (!rst && bus.imem_req && wcnt == mem_lat) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = bus.imem_addr ^ XK;
      wcnt = 0;
    end else begin
      bus.imem_ack = 1'b0;
      wcnt = (!rst && bus.imem_req) ? wcnt + 1 : 0;
    end
  endtask
  task automatic step();
    if (bus.inst_valid && bus.inst_ready) got.push_back('{bus.inst_pc, bus.inst_data});
    if (bus.imem_ack) acked.push_back(bus.imem_addr);
    @(posedge clk);
    #1;
    mem_model();
  endtask
  task automatic release_rst();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wcnt = 0;
    got.delete();
    acked.delete();
    mem_model();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.redirect_valid = 1'b0;
    release_rst();
  endtask
  task automatic wait_got(input int n, input int budget);
    for (int k = 0; k < budget && got.size() < n; k++) step();
    if (got.size() < n) chk("timeout_got", got.size(), n);
  endtask
  task automatic wait_ack(input int n, input int budget);
    for (int k = 0; k < budget && acked.size() < n; k++) step();
    if (acked.size() < n) chk("timeout_ack", acked.size(), n);
  endtask
  initial begin
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    #2 rst = 1'b1;
    #1;
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_data", bus.inst_data, 0);
    chk("rst_pc", bus.inst_pc, 0);
    // 1: streaming with one-cycle memory latency
    mem_lat = 1;
    release_rst();
    for (int k = 0; k < 10 && !bus.imem_ack; k++) step();
    chk("t1_first_ack_addr", bus.imem_addr, 0);
    step();
    chk("t1_latency_valid", 32'(bus.inst_valid), 1);
    chk("t1_head_pc", bus.inst_pc, 0);
    wait_got(4, 40);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pc", got[i].pc, 32'(i * 4));
      chk("t1_data", got[i].inst, 32'(i * 4) ^ XK);
      chk("t1_addr", acked[i], 32'(i * 4));
    end
    // 2: decode stalled, FIFO fills to DEPTH and fetch stops
    bus.inst_ready = 1'b0;
    mem_lat = 0;
    do_reset();
    repeat (12) step();
    chk("t2_acks", acked.size(), 4);
    chk("t2_req_off", 32'(bus.imem_req), 0);
    chk("t2_valid", 32'(bus.inst_valid), 1);
    chk("t2_head_pc", bus.inst_pc, 0);
    step();
    chk("t2_hold_data", bus.inst_data, XK);
    bus.inst_ready = 1'b1;
    wait_ack(5, 20);
    chk("t2_resume_addr", acked[4], 32'h10);
    wait_got(5, 20);
    chk("t2_order_pc3", got[3].pc, 32'hC);
    chk("t2_resume_pc", got[4].pc, 32'h10);
    // 3: redirect while a request is outstanding
    mem_lat = 3;
    do_reset();
    for (int k = 0; k < 10 && !bus.imem_req; k++) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h103;
    step();
    bus.redirect_valid = 1'b0;
    chk("t3_state", 32'(dut.state_q), 32'(DROP));
    chk("t3_req_held", 32'(bus.imem_req), 1);
    chk("t3_old_addr", bus.imem_addr, 0);
    chk("t3_valid", 32'(bus.inst_valid), 0);
    wait_ack(2, 30);
    chk("t3_drop_addr", acked[0], 0);
    chk("t3_new_addr", acked[1], 32'h100);
    wait_got(1, 30);
    chk("t3_first_pc", got[0].pc, 32'h100);
    chk("t3_first_data", got[0].inst, 32'h100 ^ XK);
    // 4: redirect in the same cycle as imem_ack
    mem_lat = 2;
    do_reset();
    for (int k = 0; k < 10 && !bus.imem_ack; k++) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    chk("t4_state", 32'(dut.state_q), 32'(REQ));
    chk("t4_addr", bus.imem_addr, 32'h200);
    chk("t4_valid", 32'(bus.inst_valid), 0);
    wait_got(1, 20);
    chk("t4_first_pc", got[0].pc, 32'h200);
    // 5: PC wraps past the top of the address space
    mem_lat = 1;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    step();
    bus.redirect_valid = 1'b0;
    chk("t5_addr", bus.imem_addr, 32'hFFFF_FFF8);
    wait_got(3, 30);
    chk("t5_pc0", got[0].pc, 32'hFFFF_FFF8);
    chk("t5_pc1", got[1].pc, 32'hFFFF_FFFC);
    chk("t5_pc2", got[2].pc, 32'h0);
    chk("t5_data2", got[2].inst, XK);
    // 6: asynchronous reset mid-request with two buffered words
    bus.inst_ready = 1'b0;
    mem_lat = 1;
    do_reset();
    for (int k = 0; k < 20 && !(acked.size() == 2 && bus.imem_req && !bus.imem_ack); k++) step();
    chk("t6_pre_valid", 32'(bus.inst_valid), 1);
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    #1;
    chk("t6_req", 32'(bus.imem_req), 0);
    chk("t6_addr", bus.imem_addr, 0);
    chk("t6_valid", 32'(bus.inst_valid), 0);
    chk("t6_data", bus.inst_data, 0);
    chk("t6_pc", bus.inst_pc, 0);
    bus.inst_ready = 1'b1;
    release_rst();
    wait_got(1, 20);
    chk("t6_restart_pc", got[0].pc, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
